cache_controller_nway: RTL and testbench

Parametrised successor to the 4-way cache controller: an N-way set-associative, write-back, write-allocate controller with true-LRU ages. It sits between the CPU port and the block-wide memory port, and drives the tag/data array with a whole-set read/write interface. New over the 4-way block: a WAYS parameter, valid/ready handshakes on every interface, invalid-way-first victim choice, and saturating hit/miss/evict performance counters.

---
 rtl/cache_nway_pkg.sv | 75 +++++++
 rtl/cache_controller_nway_lru.sv | 62 ++++++
 rtl/cache_controller_nway.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_controller_nway.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way cache controller.
// Holds the FSM state enum, entry field offsets, and the LRU helper functions
// (age update, hit select and victim select). The helpers take plain ints and
// fixed-width vectors, so one package serves every WAYS/AGE_W/TAG_W choice.
package cache_nway_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_TAG_CHECK,
    ST_WRITEBACK,
    ST_REFILL,
    ST_UPDATE,
    ST_RESPOND
  } state_t;

  // Upper bound on associativity that the selection helpers can scan.
  localparam int MAX_WAYS = 64;

  // Entry layout, MSB to LSB: {valid, dirty, age, tag, data}.
  // Pass block_w = 0 to get offsets inside the metadata-only slice.
  function automatic int entry_tag_lsb(input int block_w);
    return block_w;
  endfunction

  function automatic int entry_age_lsb(input int block_w, input int tag_w);
    return block_w + tag_w;
  endfunction

  function automatic int entry_dirty_bit(input int block_w, input int tag_w, input int age_w);
    return block_w + tag_w + age_w;
  endfunction

  function automatic int entry_valid_bit(input int block_w, input int tag_w, input int age_w);
    return block_w + tag_w + age_w + 1;
  endfunction

  // New age of one way once the target way becomes most recently used.
  function automatic int lru_next_age(input logic is_target, input logic valid,
                                      input int age, input int tgt_old_age);
    if (is_target) return 0;
    if (valid && (age < tgt_old_age)) return age + 1;
    return age;
  endfunction

  // Lowest set bit among the first 'ways' bits; 0 when none is set.
  function automatic int first_set(input logic [MAX_WAYS-1:0] vec, input int ways);
    int idx;
    idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if ((i < ways) && vec[i]) idx = i;
    end
    return idx;
  endfunction

  // Invalid ways are filled first, then the oldest way, then the top way.
  function automatic int victim_select(input logic [MAX_WAYS-1:0] valid_vec,
                                       input logic [MAX_WAYS-1:0] oldest_vec,
                                       input int ways);
    int v_inv;
    int v_old;
    v_inv = -1;
    v_old = -1;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (i < ways) begin
        if (!valid_vec[i]) v_inv = i;
        if (oldest_vec[i]) v_old = i;
      end
    end
    if (v_inv >= 0) return v_inv;
    if (v_old >= 0) return v_old;
    return ways - 1;
  endfunction

endpackage

// File: rtl/cache_controller_nway_lru.sv
// Combinational hit detection, victim choice and true-LRU age update.
// Ports:
//   i_meta         per-way {valid,dirty,age,tag}, way 0 in the LSBs
//   i_tag          request tag
//   i_target_way   way being written in UPDATE (drives o_new_ages)
//   o_hit/o_hit_way           lowest-index valid tag match
//   o_victim_way/o_victim_dirty  replacement way and whether it needs writeback
//   o_new_ages     per-way ages after touching i_target_way
module cache_lru_nway
  import cache_nway_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int TAG_W = 21,
  localparam int AGE_W  = $clog2(WAYS),
  localparam int META_W = 2 + AGE_W + TAG_W
) (
  input  logic [WAYS*META_W-1:0] i_meta,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic [AGE_W-1:0]       i_target_way,
  output logic                   o_hit,
  output logic [AGE_W-1:0]       o_hit_way,
  output logic [AGE_W-1:0]       o_victim_way,
  output logic                   o_victim_dirty,
  output logic [WAYS*AGE_W-1:0]  o_new_ages
);

  localparam int TAG_LSB   = entry_tag_lsb(0);
  localparam int AGE_LSB   = entry_age_lsb(0, TAG_W);
  localparam int DIRTY_BIT = entry_dirty_bit(0, TAG_W, AGE_W);
  localparam int VALID_BIT = entry_valid_bit(0, TAG_W, AGE_W);

  logic [WAYS-1:0]  w_valid;
  logic [WAYS-1:0]  w_dirty;
  logic [WAYS-1:0]  w_match;
  logic [WAYS-1:0]  w_oldest;
  logic [AGE_W-1:0] w_age [WAYS];
  int               w_tgt_old;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_valid[g]  = i_meta[g*META_W + VALID_BIT];
    assign w_dirty[g]  = i_meta[g*META_W + DIRTY_BIT];
    assign w_age[g]    = i_meta[g*META_W + AGE_LSB +: AGE_W];
    assign w_match[g]  = w_valid[g] && (i_meta[g*META_W + TAG_LSB +: TAG_W] == i_tag);
    assign w_oldest[g] = (w_age[g] == AGE_W'(WAYS - 1));
  end

  assign o_hit          = |w_match;
  assign o_hit_way      = AGE_W'(first_set(MAX_WAYS'(w_match), WAYS));
  assign o_victim_way   = AGE_W'(victim_select(MAX_WAYS'(w_valid), MAX_WAYS'(w_oldest), WAYS));
  assign o_victim_dirty = w_valid[o_victim_way] && w_dirty[o_victim_way];

  // An invalid target counts as the oldest, so every valid way ages by one.
  always_comb begin
    o_new_ages = '0;
    w_tgt_old  = w_valid[i_target_way] ? int'(w_age[i_target_way]) : (WAYS - 1);
    for (int i = 0; i < WAYS; i++) begin
      o_new_ages[i*AGE_W +: AGE_W] =
        AGE_W'(lru_next_age(AGE_W'(i) == i_target_way, w_valid[i], int'(w_age[i]), w_tgt_old));
    end
  end

endmodule

// File: rtl/cache_controller_nway.sv
// N-way set-associative write-back, write-allocate cache controller.
// Ports: clk/rst (async active-high); cpu_req_*/cpu_res_* CPU side;
// arr_* whole-set tag/data array; mem_* block-wide memory; hit/miss/evict
// saturating performance counters.
//
// state        | meaning
// ST_IDLE      | ready for a CPU request
// ST_LOOKUP    | reading the addressed set from the array
// ST_TAG_CHECK | pick hit way or victim, bump counters
// ST_WRITEBACK | writing the dirty victim block to memory
// ST_REFILL    | fetching the requested block from memory
// ST_UPDATE    | writing the whole set back with new ages/data
// ST_RESPOND   | one-cycle response strobe
module cache_controller_nway
  import cache_nway_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int OFFSET_BITS = 4,
  parameter int SET_BITS    = 7,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 16,
  localparam int BLOCK_W = WORD_W << OFFSET_BITS,
  localparam int TAG_W   = ADDR_W - SET_BITS - OFFSET_BITS,
  localparam int AGE_W   = $clog2(WAYS),
  localparam int META_W  = 2 + AGE_W + TAG_W,
  localparam int ENTRY_W = META_W + BLOCK_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic                    cpu_req_rw,
  input  logic [ADDR_W-1:0]       cpu_req_addr,
  input  logic [WORD_W-1:0]       cpu_req_wdata,
  output logic                    cpu_res_valid,
  output logic [WORD_W-1:0]       cpu_res_rdata,
  output logic                    arr_req_valid,
  output logic                    arr_req_rw,
  output logic [SET_BITS-1:0]     arr_req_set,
  input  logic                    arr_ready,
  input  logic [WAYS*ENTRY_W-1:0] arr_rdata,
  output logic [WAYS*ENTRY_W-1:0] arr_wdata,
  output logic [WAYS-1:0]         arr_way_we,
  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [BLOCK_W-1:0]      mem_req_wdata,
  input  logic                    mem_ready,
  input  logic [BLOCK_W-1:0]      mem_rdata,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count,
  output logic [CNT_W-1:0]        evict_count
);

  localparam int TAG_LSB   = entry_tag_lsb(BLOCK_W);
  localparam int AGE_LSB   = entry_age_lsb(BLOCK_W, TAG_W);
  localparam int DIRTY_BIT = entry_dirty_bit(BLOCK_W, TAG_W, AGE_W);
  localparam int VALID_BIT = entry_valid_bit(BLOCK_W, TAG_W, AGE_W);

  state_t                  r_state, w_next;
  logic                    r_rw;
  logic [ADDR_W-1:0]       r_addr;
  logic [WORD_W-1:0]       r_wdata;
  logic [WAYS*ENTRY_W-1:0] r_set_data;
  logic [AGE_W-1:0]        r_way;
  logic                    r_hit;
  logic [BLOCK_W-1:0]      r_block;
  logic [WORD_W-1:0]       r_rdata;
  logic [CNT_W-1:0]        r_hit_count, r_miss_count, r_evict_count;

  logic [TAG_W-1:0]        w_req_tag;
  logic [SET_BITS-1:0]     w_req_set;
  logic [OFFSET_BITS-1:0]  w_req_off;
  logic [WAYS*META_W-1:0]  w_meta;
  logic                    w_hit, w_victim_dirty;
  logic [AGE_W-1:0]        w_hit_way, w_victim_way, w_sel_way;
  logic [WAYS*AGE_W-1:0]   w_new_ages;
  logic [BLOCK_W-1:0]      w_merged;
  logic [WORD_W-1:0]       w_merged_word;
  logic                    w_tgt_dirty;
  logic [ENTRY_W-1:0]      w_ent;

  assign w_req_tag = r_addr[ADDR_W-1 -: TAG_W];
  assign w_req_set = r_addr[OFFSET_BITS +: SET_BITS];
  assign w_req_off = r_addr[OFFSET_BITS-1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_meta
    assign w_meta[g*META_W +: META_W] = r_set_data[g*ENTRY_W + BLOCK_W +: META_W];
  end

  cache_lru_nway #(.WAYS(WAYS), .TAG_W(TAG_W)) u_lru (
    .i_meta         (w_meta),
    .i_tag          (w_req_tag),
    .i_target_way   (r_way),
    .o_hit          (w_hit),
    .o_hit_way      (w_hit_way),
    .o_victim_way   (w_victim_way),
    .o_victim_dirty (w_victim_dirty),
    .o_new_ages     (w_new_ages)
  );

  assign w_sel_way = w_hit ? w_hit_way : w_victim_way;

  // A read keeps the dirty bit of a hit line; a freshly refilled line is clean.
  assign w_tgt_dirty = r_rw | (r_hit & r_set_data[int'(r_way)*ENTRY_W + DIRTY_BIT]);

  always_comb begin
    w_merged = r_block;
    if (r_rw) w_merged[int'(w_req_off)*WORD_W +: WORD_W] = r_wdata;
    w_merged_word = w_merged[int'(w_req_off)*WORD_W +: WORD_W];
  end

  always_comb begin
    w_next        = r_state;
    cpu_req_ready = 1'b0;
    cpu_res_valid = 1'b0;
    arr_req_valid = 1'b0;
    arr_req_rw    = 1'b0;
    arr_req_set   = '0;
    arr_way_we    = '0;
    arr_wdata     = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    w_ent         = '0;
    case (r_state)
      ST_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        arr_req_valid = 1'b1;
        arr_req_set   = w_req_set;
        if (arr_ready) w_next = ST_TAG_CHECK;
      end
      ST_TAG_CHECK: begin
        if (w_hit)               w_next = ST_UPDATE;
        else if (w_victim_dirty) w_next = ST_WRITEBACK;
        else                     w_next = ST_REFILL;
      end
      ST_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {r_set_data[int'(r_way)*ENTRY_W + TAG_LSB +: TAG_W], w_req_set,
                         {OFFSET_BITS{1'b0}}};
        mem_req_wdata = r_block;
        if (mem_ready) w_next = ST_REFILL;
      end
      ST_REFILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {w_req_tag, w_req_set, {OFFSET_BITS{1'b0}}};
        if (mem_ready) w_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        arr_req_valid = 1'b1;
        arr_req_rw    = 1'b1;
        arr_req_set   = w_req_set;
        arr_way_we    = {WAYS{1'b1}};
        for (int i = 0; i < WAYS; i++) begin
          w_ent = r_set_data[i*ENTRY_W +: ENTRY_W];
          w_ent[AGE_LSB +: AGE_W] = w_new_ages[i*AGE_W +: AGE_W];
          if (AGE_W'(i) == r_way) begin
            w_ent[VALID_BIT]            = 1'b1;
            w_ent[DIRTY_BIT]            = w_tgt_dirty;
            w_ent[TAG_LSB +: TAG_W]     = w_req_tag;
            w_ent[BLOCK_W-1:0]          = w_merged;
          end
          arr_wdata[i*ENTRY_W +: ENTRY_W] = w_ent;
        end
        if (arr_ready) w_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        cpu_res_valid = 1'b1;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_set_data    <= '0;
      r_way         <= '0;
      r_hit         <= 1'b0;
      r_block       <= '0;
      r_rdata       <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
      r_evict_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            r_rw    <= cpu_req_rw;
            r_addr  <= cpu_req_addr;
            r_wdata <= cpu_req_wdata;
          end
        end
        ST_LOOKUP: begin
          if (arr_ready) r_set_data <= arr_rdata;
        end
        ST_TAG_CHECK: begin
          r_hit   <= w_hit;
          r_way   <= w_sel_way;
          // On a miss this is the victim block, kept for a possible writeback.
          r_block <= r_set_data[int'(w_sel_way)*ENTRY_W +: BLOCK_W];
          if (w_hit) begin
            if (r_hit_count != {CNT_W{1'b1}}) r_hit_count <= r_hit_count + CNT_W'(1);
          end else begin
            if (r_miss_count != {CNT_W{1'b1}}) r_miss_count <= r_miss_count + CNT_W'(1);
            if (w_victim_dirty && (r_evict_count != {CNT_W{1'b1}}))
              r_evict_count <= r_evict_count + CNT_W'(1);
          end
        end
        ST_REFILL: begin
          if (mem_ready) r_block <= mem_rdata;
        end
        ST_UPDATE: begin
          if (arr_ready) r_rdata <= w_merged_word;
        end
        default: ;
      endcase
    end
  end

  assign cpu_res_rdata = r_rdata;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;
  assign evict_count   = r_evict_count;

endmodule

// File: tb/tb_cache_controller_nway.sv
module tb_cache_controller_nway;

  localparam int AE = 537;   // 4-way entry: 2 + 2 + 21 + 512
  localparam int BE = 159;   // 8-way entry: 2 + 3 + 26 + 128

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters (4 ways)
  logic            cpu_req_valid = 0, cpu_req_ready, cpu_req_rw = 0;
  logic [31:0]     cpu_req_addr = 0, cpu_req_wdata = 0, cpu_res_rdata;
  logic            cpu_res_valid, arr_req_valid, arr_req_rw, arr_ready = 0;
  logic [6:0]      arr_req_set;
  logic [4*AE-1:0] arr_rdata = '0, arr_wdata;
  logic [3:0]      arr_way_we;
  logic            mem_req_valid, mem_req_rw, mem_ready = 0;
  logic [31:0]     mem_req_addr;
  logic [511:0]    mem_req_wdata, mem_rdata = '0;
  logic [15:0]     hit_count, miss_count, evict_count;

  cache_controller_nway dut_a (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_res_valid(cpu_res_valid), .cpu_res_rdata(cpu_res_rdata),
    .arr_req_valid(arr_req_valid), .arr_req_rw(arr_req_rw), .arr_req_set(arr_req_set),
    .arr_ready(arr_ready), .arr_rdata(arr_rdata), .arr_wdata(arr_wdata), .arr_way_we(arr_way_we),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
  );

  // DUT B: 8 ways, 2-bit counters, small blocks
  logic            b_cpu_req_valid = 0, b_cpu_req_ready, b_cpu_req_rw = 0;
  logic [31:0]     b_cpu_req_addr = 0, b_cpu_req_wdata = 0, b_cpu_res_rdata;
  logic            b_cpu_res_valid, b_arr_req_valid, b_arr_req_rw, b_arr_ready = 0;
  logic [3:0]      b_arr_req_set;
  logic [8*BE-1:0] b_arr_rdata = '0, b_arr_wdata;
  logic [7:0]      b_arr_way_we;
  logic            b_mem_req_valid, b_mem_req_rw, b_mem_ready = 0;
  logic [31:0]     b_mem_req_addr;
  logic [127:0]    b_mem_req_wdata, b_mem_rdata = '0;
  logic [1:0]      b_hit_count, b_miss_count, b_evict_count;

  cache_controller_nway #(.OFFSET_BITS(2), .SET_BITS(4), .WAYS(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req_valid(b_cpu_req_valid), .cpu_req_ready(b_cpu_req_ready), .cpu_req_rw(b_cpu_req_rw),
    .cpu_req_addr(b_cpu_req_addr), .cpu_req_wdata(b_cpu_req_wdata),
    .cpu_res_valid(b_cpu_res_valid), .cpu_res_rdata(b_cpu_res_rdata),
    .arr_req_valid(b_arr_req_valid), .arr_req_rw(b_arr_req_rw), .arr_req_set(b_arr_req_set),
    .arr_ready(b_arr_ready), .arr_rdata(b_arr_rdata), .arr_wdata(b_arr_wdata),
    .arr_way_we(b_arr_way_we),
    .mem_req_valid(b_mem_req_valid), .mem_req_rw(b_mem_req_rw), .mem_req_addr(b_mem_req_addr),
    .mem_req_wdata(b_mem_req_wdata), .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
    .hit_count(b_hit_count), .miss_count(b_miss_count), .evict_count(b_evict_count)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_mem    = 0;
  int n_arr_wr = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req_valid) n_mem <= n_mem + 1;
    if (arr_req_valid && arr_req_rw && arr_ready) n_arr_wr <= n_arr_wr + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] a_blk(input logic [31:0] base);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  function automatic logic [AE-1:0] a_ent(input logic v, input logic d, input logic [1:0] age,
                                          input logic [20:0] tag, input logic [511:0] data);
    return {v, d, age, tag, data};
  endfunction

  function automatic logic [31:0] a_addr(input logic [20:0] tag, input logic [3:0] off);
    return {tag, 7'd5, off};
  endfunction

  function automatic logic [1:0] a_age(input logic [4*AE-1:0] w, input int i);
    return w[i*AE + 533 +: 2];
  endfunction

  function automatic logic [31:0] a_word(input logic [4*AE-1:0] w, input int i, input int k);
    return w[i*AE + k*32 +: 32];
  endfunction

  function automatic logic [127:0] b_blk(input int w);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = 32'h0B00_0000 + 32'(w*16 + i);
    return b;
  endfunction

  task automatic a_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    chk("req_ready", 64'(cpu_req_ready), 64'd1);
    cpu_req_valid = 1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_wdata = wd;
    @(negedge clk);
    cpu_req_valid = 0;
  endtask

  task automatic a_arr_read(input logic [4*AE-1:0] set_data);
    int n = 0;
    while (!(arr_req_valid && !arr_req_rw) && n < 20) begin @(negedge clk); n++; end
    chk("lookup_req", 64'(arr_req_valid && !arr_req_rw), 64'd1);
    chk("lookup_set", 64'(arr_req_set), 64'd5);
    arr_rdata = set_data; arr_ready = 1;
    @(negedge clk);
    arr_ready = 0;
  endtask

  task automatic a_mem(input logic exp_rw, input logic [31:0] exp_addr,
                       input logic [511:0] rdata, output logic [511:0] wd_seen);
    int n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("mem_req", 64'(mem_req_valid), 64'd1);
    chk("mem_rw", 64'(mem_req_rw), 64'(exp_rw));
    chk("mem_addr", 64'(mem_req_addr), 64'(exp_addr));
    wd_seen = mem_req_wdata;
    mem_rdata = rdata; mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
  endtask

  task automatic a_arr_write(output logic [4*AE-1:0] wr);
    int n = 0;
    while (!(arr_req_valid && arr_req_rw) && n < 20) begin @(negedge clk); n++; end
    chk("update_req", 64'(arr_req_valid && arr_req_rw), 64'd1);
    chk("update_we", 64'(arr_way_we), 64'hF);
    wr = arr_wdata; arr_ready = 1;
    @(negedge clk);
    arr_ready = 0;
  endtask

  task automatic a_resp(input logic [31:0] exp);
    chk("res_valid", 64'(cpu_res_valid), 64'd1);
    chk("res_rdata", 64'(cpu_res_rdata), 64'(exp));
    @(negedge clk);
    chk("res_strobe_once", 64'(cpu_res_valid), 64'd0);
  endtask

  int hit_seq [5] = '{0, 3, 7, 3, 5};

  initial begin
    logic [4*AE-1:0] set_a, wr;
    logic [511:0]    wb;
    logic [8*BE-1:0] b_set, b_w;
    logic [7:0]      mask;
    int              m0, c0, wr0, n, w;

    // Reset values
    #1;
    chk("rst_ready", 64'(cpu_req_ready), 64'd1);
    chk("rst_outs", 64'({cpu_res_valid, arr_req_valid, arr_req_rw, mem_req_valid, mem_req_rw}), 64'd0);
    chk("rst_bus", 64'(|{arr_wdata, arr_way_we, arr_req_set, mem_req_addr, mem_req_wdata, cpu_res_rdata}), 64'd0);
    chk("rst_cnt", 64'({hit_count, miss_count, evict_count}), 64'd0);
    @(negedge clk);
    rst = 0;

    // Read hit on way 0, ages {2,1,0,3}
    set_a = {a_ent(1, 0, 2'd3, 21'h333, a_blk(32'h1000_0300)),
             a_ent(1, 0, 2'd0, 21'h222, a_blk(32'h1000_0200)),
             a_ent(1, 0, 2'd1, 21'h111, a_blk(32'h1000_0100)),
             a_ent(1, 0, 2'd2, 21'hABC, a_blk(32'h1000_0000))};
    m0 = n_mem; c0 = cyc;
    a_req(0, a_addr(21'hABC, 4'd3), 32'h0);
    a_arr_read(set_a);
    a_arr_write(wr);
    chk("hit_latency", 64'(cyc - c0), 64'd4);
    a_resp(32'h1000_0003);
    chk("hit_no_mem", 64'(n_mem - m0), 64'd0);
    chk("hit_ages", 64'({a_age(wr, 3), a_age(wr, 2), a_age(wr, 1), a_age(wr, 0)}), 64'b11_01_10_00);
    chk("hit_dirty", 64'(wr[535]), 64'd0);
    chk("hit_count1", 64'(hit_count), 64'd1);

    // Read miss, all clean, way 3 oldest
    set_a = {a_ent(1, 0, 2'd3, 21'h333, a_blk(32'h1000_0300)),
             a_ent(1, 0, 2'd1, 21'h222, a_blk(32'h1000_0200)),
             a_ent(1, 0, 2'd2, 21'h111, a_blk(32'h1000_0100)),
             a_ent(1, 0, 2'd0, 21'hABC, a_blk(32'h1000_0000))};
    m0 = n_mem;
    a_req(0, a_addr(21'h456, 4'd3), 32'h0);
    a_arr_read(set_a);
    a_mem(0, a_addr(21'h456, 4'd0), a_blk(32'hFACE_B00C), wb);
    a_arr_write(wr);
    a_resp(32'hFACE_B00F);
    chk("miss_single_mem", 64'(n_mem - m0), 64'd1);
    chk("miss_ages", 64'({a_age(wr, 3), a_age(wr, 2), a_age(wr, 1), a_age(wr, 0)}), 64'b00_10_11_01);
    chk("miss_tag3", 64'(wr[3*AE + 512 +: 21]), 64'h456);
    chk("miss_v_d3", 64'(wr[3*AE + 535 +: 2]), 64'b10);
    chk("miss_cnt", 64'({miss_count, evict_count}), {32'd1, 32'd0} >> 16);

    // Write miss, dirty victim way 0
    set_a = {a_ent(1, 0, 2'd2, 21'h333, a_blk(32'h1000_0300)),
             a_ent(1, 0, 2'd1, 21'h222, a_blk(32'h1000_0200)),
             a_ent(1, 0, 2'd0, 21'h111, a_blk(32'h1000_0100)),
             a_ent(1, 1, 2'd3, 21'h123, a_blk(32'h2000_0000))};
    a_req(1, a_addr(21'h789, 4'd1), 32'hCAFE_BABE);
    a_arr_read(set_a);
    a_mem(1, a_addr(21'h123, 4'd0), '0, wb);
    chk("wb_word0", 64'(wb[31:0]), 64'h2000_0000);
    chk("wb_word15", 64'(wb[511:480]), 64'h2000_000F);
    a_mem(0, a_addr(21'h789, 4'd0), a_blk(32'h3000_0000), wb);
    a_arr_write(wr);
    a_resp(32'hCAFE_BABE);
    chk("wr_word1", 64'(a_word(wr, 0, 1)), 64'hCAFE_BABE);
    chk("wr_word2", 64'(a_word(wr, 0, 2)), 64'h3000_0002);
    chk("wr_v_d0", 64'(wr[535 +: 2]), 64'b11);
    chk("wr_tag0", 64'(wr[512 +: 21]), 64'h789);
    chk("wr_ages", 64'({a_age(wr, 3), a_age(wr, 2), a_age(wr, 1), a_age(wr, 0)}), 64'b11_10_01_00);
    chk("wr_evict", 64'(evict_count), 64'd1);
    chk("wr_miss", 64'(miss_count), 64'd2);

    // Miss with ways 2 and 3 invalid: fill way 2
    set_a = {a_ent(0, 1, 2'd0, 21'h333, a_blk(32'h1000_0300)),
             a_ent(0, 1, 2'd0, 21'h222, a_blk(32'h1000_0200)),
             a_ent(1, 0, 2'd1, 21'h111, a_blk(32'h1000_0100)),
             a_ent(1, 0, 2'd0, 21'hABC, a_blk(32'h1000_0000))};
    a_req(0, a_addr(21'h555, 4'd0), 32'h0);
    a_arr_read(set_a);
    a_mem(0, a_addr(21'h555, 4'd0), a_blk(32'h4000_0000), wb);
    a_arr_write(wr);
    a_resp(32'h4000_0000);
    chk("inv_ages", 64'({a_age(wr, 3), a_age(wr, 2), a_age(wr, 1), a_age(wr, 0)}), 64'b00_00_10_01);
    chk("inv_way2", 64'({wr[2*AE + 535 +: 2], wr[2*AE + 512 +: 21]}), 64'({2'b10, 21'h555}));
    chk("inv_way3", 64'(wr[3*AE + 536]), 64'd0);
    chk("inv_evict", 64'(evict_count), 64'd1);

    // Reset during REFILL
    a_req(0, a_addr(21'h999, 4'd0), 32'h0);
    a_arr_read(set_a);
    n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("refill_reached", 64'({mem_req_valid, mem_req_rw}), 64'b10);
    wr0 = n_arr_wr;
    #2 rst = 1;
    #1;
    chk("arst_ready", 64'(cpu_req_ready), 64'd1);
    chk("arst_outs", 64'({mem_req_valid, arr_req_valid, cpu_res_valid, |mem_req_addr}), 64'd0);
    chk("arst_cnt", 64'({hit_count, miss_count, evict_count}), 64'd0);
    @(negedge clk);
    rst = 0;
    chk("arst_no_arr_wr", 64'(n_arr_wr - wr0), 64'd0);
    set_a = {a_ent(1, 0, 2'd3, 21'h333, a_blk(32'h1000_0300)),
             a_ent(1, 0, 2'd0, 21'h222, a_blk(32'h1000_0200)),
             a_ent(1, 0, 2'd1, 21'h111, a_blk(32'h1000_0100)),
             a_ent(1, 0, 2'd2, 21'hABC, a_blk(32'h1000_0000))};
    a_req(0, a_addr(21'hABC, 4'd7), 32'h0);
    a_arr_read(set_a);
    a_arr_write(wr);
    a_resp(32'h1000_0007);
    chk("post_rst_hits", 64'({hit_count, miss_count}), 64'h1_0000);

    // 8-way: five hits saturate a 2-bit hit counter
    for (int i = 0; i < 8; i++)
      b_set[i*BE +: BE] = {1'b1, 1'b0, 3'(7 - i), 26'(32'h10 + i), b_blk(i)};
    for (int k = 0; k < 5; k++) begin
      w = hit_seq[k];
      chk("b_ready", 64'(b_cpu_req_ready), 64'd1);
      b_cpu_req_valid = 1; b_cpu_req_rw = 0;
      b_cpu_req_addr = {26'(32'h10 + w), 4'd2, 2'd1};
      @(negedge clk);
      b_cpu_req_valid = 0;
      n = 0;
      while (!b_arr_req_valid && n < 20) begin @(negedge clk); n++; end
      chk("b_lookup", 64'({b_arr_req_valid, b_arr_req_rw, b_arr_req_set}), 64'b10_0010);
      b_arr_rdata = b_set; b_arr_ready = 1;
      @(negedge clk);
      b_arr_ready = 0;
      n = 0;
      while (!(b_arr_req_valid && b_arr_req_rw) && n < 20) begin @(negedge clk); n++; end
      chk("b_update", 64'(b_arr_req_valid && b_arr_req_rw), 64'd1);
      chk("b_no_mem", 64'(b_mem_req_valid), 64'd0);
      b_w = b_arr_wdata; b_arr_ready = 1;
      @(negedge clk);
      b_arr_ready = 0;
      chk("b_res_valid", 64'(b_cpu_res_valid), 64'd1);
      chk("b_rdata", 64'(b_cpu_res_rdata), 64'(32'h0B00_0000 + 32'(w*16 + 1)));
      mask = '0;
      for (int i = 0; i < 8; i++) mask[b_w[i*BE + 154 +: 3]] = 1'b1;
      chk("b_age_perm", 64'(mask), 64'hFF);
      chk("b_target_age", 64'(b_w[w*BE + 154 +: 3]), 64'd0);
      chk("b_hit_count", 64'(b_hit_count), 64'(k < 3 ? k + 1 : 3));
      b_set = b_w;
      @(negedge clk);
    end
    chk("b_miss_count", 64'(b_miss_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
